// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder decoder: resolution modes,
// phase symbol encodings, x1 FSM states and the step decode function.
package quad_enc_pkg;

  localparam int MODE_X1 = 0;
  localparam int MODE_X2 = 1;
  localparam int MODE_X4 = 2;

  // Phase symbols are {A,B}.
  typedef logic [1:0] phase_t;

  localparam phase_t PH_Z  = 2'b00;
  localparam phase_t PH_A  = 2'b10;
  localparam phase_t PH_AB = 2'b11;
  localparam phase_t PH_B  = 2'b01;

  typedef enum logic [2:0] {
    ST_S0   = 3'd0,
    ST_CW1  = 3'd1,
    ST_CW2  = 3'd2,
    ST_CW3  = 3'd3,
    ST_CCW1 = 3'd4,
    ST_CCW2 = 3'd5,
    ST_CCW3 = 3'd6,
    ST_ERR  = 3'd7
  } x1_state_t;

  typedef struct packed {
    logic changed;
    logic legal;
    logic cw;
  } step_t;

  // Position of a symbol in the CW gray sequence Z->A->AB->B.
  function automatic logic [1:0] gray_index(input phase_t ph);
    logic [1:0] idx;
    unique case (ph)
      PH_Z:    idx = 2'd0;
      PH_A:    idx = 2'd1;
      PH_AB:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // A legal step changes exactly one phase; CW when it advances one gray position.
  function automatic step_t decode_step(input phase_t prev, input phase_t curr);
    step_t      s;
    logic [1:0] delta;
    delta     = gray_index(curr) - gray_index(prev);
    s.changed = (prev != curr);
    s.legal   = s.changed && ((prev ^ curr) != 2'b11);
    s.cw      = s.legal && (delta == 2'd1);
    return s;
  endfunction

endpackage

// File: rtl/quad_enc_channel.sv
// One encoder channel: input synchroniser, previous-sample register, x1 detent
// FSM, signed position counter with wrap/saturate, and sticky error flag.
module quad_enc_channel
  import quad_enc_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = MODE_X4,
  parameter int SATURATE    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        phase_a,
  input  logic                        phase_b,
  input  logic                        clear,
  input  logic                        enable,
  output logic                        cnt,
  output logic                        cnt_cw,
  output logic signed [CNT_WIDTH-1:0] position,
  output logic                        error
);

  localparam logic signed [CNT_WIDTH-1:0] POS_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic signed [CNT_WIDTH-1:0] POS_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic signed [CNT_WIDTH-1:0] POS_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  phase_t                 curr;
  phase_t                 prev;
  step_t                  step;
  logic                   active;

  x1_state_t              state;
  x1_state_t              state_next;
  logic                   pulse;
  logic                   pulse_cw;
  logic signed [CNT_WIDTH-1:0] position_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, which is what makes the shift chain a real pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      prev   <= PH_Z;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], phase_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], phase_b};
      prev   <= curr;
    end
  end

  assign curr   = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign step   = decode_step(prev, curr);
  assign active = enable && step.changed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_S0;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (active) begin
      if (!step.legal) begin
        state_next = ST_ERR;
      end else begin
        unique case (state)
          ST_S0:   if (curr == PH_A) state_next = ST_CW1;
                   else if (curr == PH_B) state_next = ST_CCW1;
          ST_CW1:  if (curr == PH_AB) state_next = ST_CW2;
                   else if (curr == PH_Z) state_next = ST_S0;
          ST_CW2:  if (curr == PH_B) state_next = ST_CW3;
                   else if (curr == PH_A) state_next = ST_CW1;
          ST_CW3:  if (curr == PH_Z) state_next = ST_S0;
                   else if (curr == PH_AB) state_next = ST_CW2;
          ST_CCW1: if (curr == PH_AB) state_next = ST_CCW2;
                   else if (curr == PH_Z) state_next = ST_S0;
          ST_CCW2: if (curr == PH_A) state_next = ST_CCW3;
                   else if (curr == PH_B) state_next = ST_CCW1;
          ST_CCW3: if (curr == PH_Z) state_next = ST_S0;
                   else if (curr == PH_AB) state_next = ST_CCW2;
          ST_ERR:  if (curr == PH_Z) state_next = ST_S0;
          default: state_next = ST_S0;
        endcase
      end
    end
  end

  // Pulse decision per resolution; x1 only fires when a full detent completes.
  always_comb begin
    pulse    = 1'b0;
    pulse_cw = 1'b0;
    if (active && step.legal) begin
      if (MODE == MODE_X4) begin
        pulse    = 1'b1;
        pulse_cw = step.cw;
      end else if (MODE == MODE_X2) begin
        pulse    = (curr == PH_AB) || (curr == PH_Z);
        pulse_cw = step.cw;
      end else begin
        if (curr == PH_Z && state == ST_CW3) begin
          pulse    = 1'b1;
          pulse_cw = 1'b1;
        end else if (curr == PH_Z && state == ST_CCW3) begin
          pulse    = 1'b1;
          pulse_cw = 1'b0;
        end
      end
    end
  end

  always_comb begin
    position_next = position;
    if (pulse_cw) begin
      if (SATURATE == 0 || position != POS_MAX) position_next = position + POS_ONE;
    end else begin
      if (SATURATE == 0 || position != POS_MIN) position_next = position - POS_ONE;
    end
  end

  // Clear beats a coincident step for position and error; the pulse still goes out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 1'b0;
      cnt_cw   <= 1'b0;
      position <= '0;
      error    <= 1'b0;
    end else begin
      cnt    <= pulse;
      cnt_cw <= pulse & pulse_cw;
      if (clear) begin
        position <= '0;
        error    <= 1'b0;
      end else begin
        if (active && !step.legal) error <= 1'b1;
        if (pulse) position <= position_next;
      end
    end
  end

endmodule

// File: rtl/quad_encoder_counter.sv
// Multi-channel quadrature decoder: shared post-reset prime counter plus one
// independent decoder channel per encoder, outputs packed per channel.
module quad_encoder_counter
  import quad_enc_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 2,
  parameter int SATURATE    = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [CHANNELS-1:0]           i_phase_a,
  input  logic [CHANNELS-1:0]           i_phase_b,
  input  logic [CHANNELS-1:0]           i_clear,
  output logic [CHANNELS-1:0]           o_cnt,
  output logic [CHANNELS-1:0]           o_cnt_cw,
  output logic [CHANNELS*CNT_WIDTH-1:0] o_position,
  output logic [CHANNELS-1:0]           o_error
);

  localparam int PRIME_CYCLES = SYNC_STAGES + 1;
  localparam int PW           = $clog2(PRIME_CYCLES + 1);
  localparam logic [PW-1:0] PRIME_DONE = PW'(PRIME_CYCLES);

  logic [PW-1:0] prime_cnt;
  logic          enable;

  // Decode stays off until the synchronisers and previous-sample registers
  // hold the real pin levels, so the reset value never looks like a step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    prime_cnt <= '0;
    else if (prime_cnt != PRIME_DONE) prime_cnt <= prime_cnt + PW'(1);
  end

  assign enable = (prime_cnt == PRIME_DONE);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic signed [CNT_WIDTH-1:0] position;

    quad_enc_channel #(
      .CNT_WIDTH   (CNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (MODE),
      .SATURATE    (SATURATE)
    ) u_channel (
      .clk      (i_clk),
      .rst      (i_rst),
      .phase_a  (i_phase_a[g]),
      .phase_b  (i_phase_b[g]),
      .clear    (i_clear[g]),
      .enable   (enable),
      .cnt      (o_cnt[g]),
      .cnt_cw   (o_cnt_cw[g]),
      .position (position),
      .error    (o_error[g])
    );

    assign o_position[g*CNT_WIDTH +: CNT_WIDTH] = position;
  end

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench: five decoder configurations share the same pin stimulus and
// each scenario checks the instances it concerns against hand-derived values.
module tb_quad_encoder_counter;

  logic       clk;
  logic       rst;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] clear;

  logic [1:0]  cnt_x4, dir_x4, err_x4;
  logic [31:0] pos_x4;
  logic [1:0]  cnt_x2, dir_x2, err_x2;
  logic [31:0] pos_x2;
  logic [1:0]  cnt_x1, dir_x1, err_x1;
  logic [31:0] pos_x1;
  logic [1:0]  cnt_w4, dir_w4, err_w4;
  logic [7:0]  pos_w4;
  logic [1:0]  cnt_s4, dir_s4, err_s4;
  logic [7:0]  pos_s4;

  int checks = 0;
  int errors = 0;

  int p_x4 [2];
  int c_x4 [2];
  int p_x2 [2];
  int c_x2 [2];
  int p_x1 [2];
  int c_x1 [2];
  int p_s4;

  quad_encoder_counter #(.CHANNELS(2), .CNT_WIDTH(16), .MODE(2), .SATURATE(0)) u_x4 (
    .i_clk(clk), .i_rst(rst), .i_phase_a(a), .i_phase_b(b), .i_clear(clear),
    .o_cnt(cnt_x4), .o_cnt_cw(dir_x4), .o_position(pos_x4), .o_error(err_x4));

  quad_encoder_counter #(.CHANNELS(2), .CNT_WIDTH(16), .MODE(1), .SATURATE(0)) u_x2 (
    .i_clk(clk), .i_rst(rst), .i_phase_a(a), .i_phase_b(b), .i_clear(clear),
    .o_cnt(cnt_x2), .o_cnt_cw(dir_x2), .o_position(pos_x2), .o_error(err_x2));

  quad_encoder_counter #(.CHANNELS(2), .CNT_WIDTH(16), .MODE(0), .SATURATE(0)) u_x1 (
    .i_clk(clk), .i_rst(rst), .i_phase_a(a), .i_phase_b(b), .i_clear(clear),
    .o_cnt(cnt_x1), .o_cnt_cw(dir_x1), .o_position(pos_x1), .o_error(err_x1));

  quad_encoder_counter #(.CHANNELS(2), .CNT_WIDTH(4), .MODE(2), .SATURATE(0)) u_w4 (
    .i_clk(clk), .i_rst(rst), .i_phase_a(a), .i_phase_b(b), .i_clear(clear),
    .o_cnt(cnt_w4), .o_cnt_cw(dir_w4), .o_position(pos_w4), .o_error(err_w4));

  quad_encoder_counter #(.CHANNELS(2), .CNT_WIDTH(4), .MODE(2), .SATURATE(1)) u_s4 (
    .i_clk(clk), .i_rst(rst), .i_phase_a(a), .i_phase_b(b), .i_clear(clear),
    .o_cnt(cnt_s4), .o_cnt_cw(dir_s4), .o_position(pos_s4), .o_error(err_s4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_sym(input int ch, input logic [1:0] sym);
    a[ch] = sym[1];
    b[ch] = sym[0];
  endtask

  task automatic clear_acc();
    for (int c = 0; c < 2; c++) begin
      p_x4[c] = 0; c_x4[c] = 0;
      p_x2[c] = 0; c_x2[c] = 0;
      p_x1[c] = 0; c_x1[c] = 0;
    end
    p_s4 = 0;
  endtask

  // Advance n cycles, sampling outputs on each falling edge.
  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        p_x4[c] += int'(cnt_x4[c]);
        c_x4[c] += int'(cnt_x4[c] & dir_x4[c]);
        p_x2[c] += int'(cnt_x2[c]);
        c_x2[c] += int'(cnt_x2[c] & dir_x2[c]);
        p_x1[c] += int'(cnt_x1[c]);
        c_x1[c] += int'(cnt_x1[c] & dir_x1[c]);
      end
      p_s4 += int'(cnt_s4[0]);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    a     = 2'b00;
    b     = 2'b00;
    clear = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    clear_acc();
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 2'b00; b = 2'b00; clear = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if ({cnt_x4, dir_x4, err_x4, pos_x4} !== 38'd0) begin
      $display("FAIL reset_x4: got %h expected 0", {cnt_x4, dir_x4, err_x4, pos_x4}); errors++;
    end
    checks++;
    if ({cnt_x1, err_x1, pos_x1, cnt_w4, pos_w4, cnt_s4, pos_s4} !== 56'd0) begin
      $display("FAIL reset_others: got %h expected 0",
               {cnt_x1, err_x1, pos_x1, cnt_w4, pos_w4, cnt_s4, pos_s4}); errors++;
    end
  endtask

  task automatic test_latency();
    do_reset();
    set_sym(0, 2'b10);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cnt_x4[0] !== 1'b0) begin
      $display("FAIL latency_early: got %b expected 0", cnt_x4[0]); errors++;
    end
    @(negedge clk);
    checks++;
    if ({cnt_x4[0], dir_x4[0]} !== 2'b11 || pos_x4[15:0] !== 16'd1) begin
      $display("FAIL latency_edge3: got cnt/cw %b pos %0d expected 11 pos 1",
               {cnt_x4[0], dir_x4[0]}, pos_x4[15:0]); errors++;
    end
  endtask

  task automatic test_x4_cw();
    logic [1:0] seq [5];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_sym(0, seq[i]);
      hold(4);
    end
    checks++;
    if (p_x4[0] !== 4 || c_x4[0] !== 4 || pos_x4[15:0] !== 16'd4) begin
      $display("FAIL x4_cw: got pulses %0d cw %0d pos %0d expected 4 4 4",
               p_x4[0], c_x4[0], pos_x4[15:0]); errors++;
    end
    checks++;
    if (p_x4[1] !== 0 || pos_x4[31:16] !== 16'd0) begin
      $display("FAIL x4_ch1_idle: got pulses %0d pos %0d expected 0 0", p_x4[1], pos_x4[31:16]); errors++;
    end
    checks++;
    if (p_x2[0] !== 2 || c_x2[0] !== 2 || pos_x2[15:0] !== 16'd2) begin
      $display("FAIL x2_cw: got pulses %0d cw %0d pos %0d expected 2 2 2",
               p_x2[0], c_x2[0], pos_x2[15:0]); errors++;
    end
    checks++;
    if (p_x1[0] !== 1 || c_x1[0] !== 1 || pos_x1[15:0] !== 16'd1) begin
      $display("FAIL x1_cw: got pulses %0d cw %0d pos %0d expected 1 1 1",
               p_x1[0], c_x1[0], pos_x1[15:0]); errors++;
    end
  endtask

  task automatic test_x1();
    logic [1:0] ccw [4];
    logic [1:0] part [4];
    ccw  = '{2'b01, 2'b11, 2'b10, 2'b00};
    part = '{2'b10, 2'b11, 2'b10, 2'b00};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_sym(0, ccw[i]);
      hold(4);
    end
    checks++;
    if (p_x1[0] !== 0) begin
      $display("FAIL x1_ccw_early: got pulses %0d expected 0", p_x1[0]); errors++;
    end
    set_sym(0, ccw[3]);
    hold(4);
    checks++;
    if (p_x1[0] !== 1 || c_x1[0] !== 0 || pos_x1[15:0] !== 16'hFFFF) begin
      $display("FAIL x1_ccw: got pulses %0d cw %0d pos %h expected 1 0 ffff",
               p_x1[0], c_x1[0], pos_x1[15:0]); errors++;
    end
    for (int i = 0; i < 4; i++) begin
      set_sym(0, part[i]);
      hold(4);
    end
    checks++;
    if (p_x1[0] !== 1 || pos_x1[15:0] !== 16'hFFFF || err_x1[0] !== 1'b0) begin
      $display("FAIL x1_partial: got pulses %0d pos %h err %b expected 1 ffff 0",
               p_x1[0], pos_x1[15:0], err_x1[0]); errors++;
    end
  endtask

  task automatic test_illegal_clear();
    do_reset();
    set_sym(0, 2'b11);
    hold(4);
    checks++;
    if (err_x4[0] !== 1'b1 || p_x4[0] !== 0 || pos_x4[15:0] !== 16'd0 || err_x1[0] !== 1'b1) begin
      $display("FAIL illegal: got err %b pulses %0d pos %0d x1err %b expected 1 0 0 1",
               err_x4[0], p_x4[0], pos_x4[15:0], err_x1[0]); errors++;
    end
    set_sym(0, 2'b01);
    hold(4);
    set_sym(0, 2'b00);
    hold(4);
    checks++;
    if (err_x4[0] !== 1'b1 || pos_x4[15:0] !== 16'd2 || err_x4[1] !== 1'b0) begin
      $display("FAIL error_sticky: got err %b pos %0d ch1err %b expected 1 2 0",
               err_x4[0], pos_x4[15:0], err_x4[1]); errors++;
    end
    clear = 2'b01;
    hold(1);
    clear = 2'b00;
    checks++;
    if (err_x4[0] !== 1'b0 || pos_x4[15:0] !== 16'd0) begin
      $display("FAIL clear: got err %b pos %0d expected 0 0", err_x4[0], pos_x4[15:0]); errors++;
    end
  endtask

  task automatic test_saturate();
    logic [1:0] cyc [4];
    logic [3:0] exp_wrap;
    logic [3:0] exp_sat;
    cyc = '{2'b10, 2'b11, 2'b01, 2'b00};
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      set_sym(0, cyc[(i - 1) % 4]);
      hold(4);
      exp_wrap = 4'(i);
      exp_sat  = (i > 7) ? 4'd7 : 4'(i);
      checks++;
      if (pos_w4[3:0] !== exp_wrap || pos_s4[3:0] !== exp_sat) begin
        $display("FAIL sat_step%0d: got wrap %h sat %h expected %h %h",
                 i, pos_w4[3:0], pos_s4[3:0], exp_wrap, exp_sat); errors++;
      end
    end
    checks++;
    if (p_s4 !== 8 || pos_x4[15:0] !== 16'd8) begin
      $display("FAIL sat_pulses: got %0d pos16 %0d expected 8 8", p_s4, pos_x4[15:0]); errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_sym(0, 2'b10);
    hold(4);
    set_sym(0, 2'b11);
    repeat (3) @(negedge clk);
    checks++;
    if (cnt_x4[0] !== 1'b1 || pos_x4[15:0] !== 16'd2) begin
      $display("FAIL pre_reset: got cnt %b pos %0d expected 1 2", cnt_x4[0], pos_x4[15:0]); errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_x4 !== 2'b00 || pos_x4 !== 32'd0 || err_x4 !== 2'b00) begin
      $display("FAIL async_reset: got cnt %b pos %h err %b expected 0", cnt_x4, pos_x4, err_x4); errors++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_acc();
    hold(6);
    checks++;
    if (p_x4[0] !== 0 || err_x4[0] !== 1'b0 || pos_x4[15:0] !== 16'd0) begin
      $display("FAIL prime: got pulses %0d err %b pos %0d expected 0 0 0",
               p_x4[0], err_x4[0], pos_x4[15:0]); errors++;
    end
    set_sym(0, 2'b01);
    hold(4);
    checks++;
    if (p_x4[0] !== 1 || c_x4[0] !== 1 || pos_x4[15:0] !== 16'd1) begin
      $display("FAIL post_reset_step: got pulses %0d cw %0d pos %0d expected 1 1 1",
               p_x4[0], c_x4[0], pos_x4[15:0]); errors++;
    end
  endtask

  task automatic test_clear_with_step();
    do_reset();
    set_sym(0, 2'b10);
    hold(4);
    set_sym(0, 2'b11);
    set_sym(1, 2'b10);
    @(negedge clk);
    @(negedge clk);
    clear = 2'b01;
    @(negedge clk);
    clear = 2'b00;
    checks++;
    if (cnt_x4[0] !== 1'b1 || pos_x4[15:0] !== 16'd0) begin
      $display("FAIL clear_step_ch0: got cnt %b pos %0d expected 1 0", cnt_x4[0], pos_x4[15:0]); errors++;
    end
    checks++;
    if (cnt_x4[1] !== 1'b1 || dir_x4[1] !== 1'b1 || pos_x4[31:16] !== 16'd1) begin
      $display("FAIL clear_step_ch1: got cnt %b cw %b pos %0d expected 1 1 1",
               cnt_x4[1], dir_x4[1], pos_x4[31:16]); errors++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    a     = 2'b00;
    b     = 2'b00;
    clear = 2'b00;
    clear_acc();
    test_reset();
    test_latency();
    test_x4_cw();
    test_x1();
    test_illegal_clear();
    test_saturate();
    test_reset_mid();
    test_clear_with_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
